// File: rtl/cross_bar_arbiter_if.sv
// Request/grant bundle between the masters, the commutation block and the
// per-slave round-robin arbiter. The slave modport is the arbiter's view;
// the master modport is the side that drives requests and finish pulses.
interface cross_bar_arbiter_if #(
  parameter int QTY_OF_DEVICES = 4,
  parameter int ADDR_WIDTH     = 32
);

  logic [QTY_OF_DEVICES-1:0]                      master_req;
  logic [QTY_OF_DEVICES-1:0][ADDR_WIDTH-1:0]      master_addr;
  logic [QTY_OF_DEVICES-1:0]                      session_is_finished;
  logic [QTY_OF_DEVICES-1:0][QTY_OF_DEVICES-1:0]  granted_matrix;
  logic [QTY_OF_DEVICES-1:0]                      slave_busy;

  modport master (
    output master_req,
    output master_addr,
    output session_is_finished,
    input  granted_matrix,
    input  slave_busy
  );

  modport slave (
    input  master_req,
    input  master_addr,
    input  session_is_finished,
    output granted_matrix,
    output slave_busy
  );

endinterface

// File: rtl/cross_bar_arbiter.sv
// Per-slave round-robin arbiter feeding the crossbar commutation block.
// Each slave owns a small IDLE/GRANTED/RELEASE FSM, a one-hot grant register
// and a round-robin pointer. A grant is held for a whole session and dropped
// on that slave's session_is_finished pulse; slaves arbitrate independently.
module cross_bar_arbiter #(
  parameter int QTY_OF_DEVICES = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_WIDTH      = $clog2(QTY_OF_DEVICES)
) (
  input  logic             clk,
  input  logic             rst_n,
  cross_bar_arbiter_if.slave bus
);

  localparam int N = QTY_OF_DEVICES;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef logic [N-1:0]         vec_t;
  typedef logic [SEL_WIDTH-1:0] idx_t;

  // Round-robin search: first set request starting just after the pointer,
  // wrapping modulo N, so the last winner gets the lowest priority.
  function automatic vec_t rr_pick(input vec_t req, input idx_t ptr);
    vec_t pick;
    logic found;
    idx_t idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = ptr + idx_t'(k);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  // Binary index of a one-hot grant vector (zero when the vector is empty).
  function automatic idx_t onehot_index(input vec_t oh);
    idx_t idx;
    idx = '0;
    for (int m = 0; m < N; m++) begin
      if (oh[m]) idx = idx_t'(m);
    end
    return idx;
  endfunction

  vec_t   cand      [N];
  vec_t   pick      [N];
  vec_t   grant_reg [N];
  idx_t   rr_ptr    [N];
  state_t state     [N];
  vec_t   col       [N];

  // The low address bits go on to the selected slave; only the top field is
  // decoded here, so the rest is folded into a deliberately unused sink.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.master_addr;

  // Decode each master's target slave from the top address field.
  always_comb begin
    for (int s = 0; s < N; s++) begin
      for (int m = 0; m < N; m++) begin
        cand[s][m] = bus.master_req[m] &&
                     (bus.master_addr[m][ADDR_WIDTH-1 -: SEL_WIDTH] == idx_t'(s));
      end
    end
  end

  // Round-robin winner per slave, consumed only when that slave is IDLE.
  always_comb begin
    for (int s = 0; s < N; s++) begin
      pick[s] = rr_pick(cand[s], rr_ptr[s]);
    end
  end

  // Per-slave session FSM: grant on request, hold until finish, one dead cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < N; s++) begin
        state[s]     <= IDLE;
        grant_reg[s] <= '0;
        rr_ptr[s]    <= idx_t'(N - 1);
      end
    end else begin
      for (int s = 0; s < N; s++) begin
        case (state[s])
          IDLE: begin
            if (|cand[s]) begin
              grant_reg[s] <= pick[s];
              state[s]     <= GRANTED;
            end else begin
              grant_reg[s] <= '0;
            end
          end
          GRANTED: begin
            if (bus.session_is_finished[s]) begin
              rr_ptr[s]    <= onehot_index(grant_reg[s]);
              grant_reg[s] <= '0;
              state[s]     <= RELEASE;
            end
          end
          RELEASE: begin
            grant_reg[s] <= '0;
            state[s]     <= IDLE;
          end
          default: begin
            grant_reg[s] <= '0;
            state[s]     <= IDLE;
          end
        endcase
      end
    end
  end

  // Mask a row during its finish pulse so the commutation FSM never sees a
  // stale grant; busy reflects the grant register itself.
  always_comb begin
    for (int s = 0; s < N; s++) begin
      bus.granted_matrix[s] = grant_reg[s] & {N{~bus.session_is_finished[s]}};
      bus.slave_busy[s]     = |grant_reg[s];
    end
  end

  // Column view of the grant matrix: col[m] bit s = master m owns slave s.
  always_comb begin
    for (int m = 0; m < N; m++) begin
      for (int s = 0; s < N; s++) begin
        col[m][s] = bus.granted_matrix[s][m];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_onehot_checks
    a_row_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(bus.granted_matrix[g]));
    a_col_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(col[g]));
  end

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Bench for cross_bar_arbiter: a table of per-cycle vectors (requests, slave
// selects, finish pulses and the expected grant matrix / busy bits), a
// scoreboard queue filled as each vector is driven and drained at the
// following negedge, and a hand-written asynchronous reset sequence.
module tb_cross_bar_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  cross_bar_arbiter_if #(.QTY_OF_DEVICES(N), .ADDR_WIDTH(AW)) bus();

  cross_bar_arbiter #(.QTY_OF_DEVICES(N), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] req;
    logic [7:0] sel;
    logic [3:0] fin;
    logic [15:0] gm;
    logic [3:0] busy;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] gm;
    logic [3:0]  busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mkVec(string name, logic [3:0] req, logic [7:0] sel,
                                 logic [3:0] fin, logic [15:0] gm, logic [3:0] busy);
    vec_t v;
    v.name = name;
    v.req  = req;
    v.sel  = sel;
    v.fin  = fin;
    v.gm   = gm;
    v.busy = busy;
    return v;
  endfunction

  task automatic addVec(string name, logic [3:0] req, logic [7:0] sel,
                        logic [3:0] fin, logic [15:0] gm, logic [3:0] busy);
    vecs.push_back(mkVec(name, req, sel, fin, gm, busy));
  endtask

  task automatic checkValue(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; queue its expectation.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    bus.master_req          = v.req;
    bus.session_is_finished = v.fin;
    for (int m = 0; m < N; m++) begin
      bus.master_addr[m] = {v.sel[2*m +: 2], (AW-2)'($urandom)};
    end
    e.name = v.name;
    e.gm   = v.gm;
    e.busy = v.busy;
    sb.push_back(e);
  endtask

  // Sample at the falling edge and compare against the oldest expectation.
  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      checkValue({e.name, " granted_matrix"}, 16'(bus.granted_matrix), e.gm);
      checkValue({e.name, " slave_busy"}, 16'(bus.slave_busy), 16'(e.busy));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.master_req          = '0;
    bus.master_addr         = '0;
    bus.session_is_finished = '0;

    // sel packs master selects as {m3,m2,m1,m0}; gm hex digit s = row s.
    // Single request, late drop ignored, finish masks then releases.
    addVec("t1 idle",        4'b0000, 8'b00_00_00_00, 4'b0000, 16'h0000, 4'b0000);
    addVec("t1 req",         4'b0001, 8'b00_00_00_10, 4'b0000, 16'h0000, 4'b0000);
    addVec("t1 grant",       4'b0001, 8'b00_00_00_10, 4'b0000, 16'h0100, 4'b0100);
    addVec("t1 hold",        4'b0000, 8'b00_00_00_10, 4'b0000, 16'h0100, 4'b0100);
    addVec("t1 fin",         4'b0000, 8'b00_00_00_10, 4'b0100, 16'h0000, 4'b0100);
    addVec("t1 release",     4'b0000, 8'b00_00_00_10, 4'b0000, 16'h0000, 4'b0000);
    addVec("t1 back idle",   4'b0000, 8'b00_00_00_10, 4'b0000, 16'h0000, 4'b0000);
    // M0, M1, M3 contend for slave 1: order M0, M1, M3, M0.
    addVec("t2 req",         4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0000, 4'b0000);
    addVec("t2 M0",          4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0010, 4'b0010);
    addVec("t2 M0 hold",     4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0010, 4'b0010);
    addVec("t2 M0 fin",      4'b1011, 8'b01_00_01_01, 4'b0010, 16'h0000, 4'b0010);
    addVec("t2 gap a1",      4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0000, 4'b0000);
    addVec("t2 gap a2",      4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0000, 4'b0000);
    addVec("t2 M1",          4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0020, 4'b0010);
    addVec("t2 M1 fin",      4'b1011, 8'b01_00_01_01, 4'b0010, 16'h0000, 4'b0010);
    addVec("t2 gap b1",      4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0000, 4'b0000);
    addVec("t2 gap b2",      4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0000, 4'b0000);
    addVec("t2 M3",          4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0080, 4'b0010);
    addVec("t2 M3 fin",      4'b1011, 8'b01_00_01_01, 4'b0010, 16'h0000, 4'b0010);
    addVec("t2 gap c1",      4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0000, 4'b0000);
    addVec("t2 gap c2",      4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0000, 4'b0000);
    addVec("t2 M0 again",    4'b1011, 8'b01_00_01_01, 4'b0000, 16'h0010, 4'b0010);
    addVec("t2 close",       4'b0000, 8'b01_00_01_01, 4'b0010, 16'h0000, 4'b0010);
    addVec("t2 release",     4'b0000, 8'b00_00_00_00, 4'b0000, 16'h0000, 4'b0000);
    addVec("t2 idle",        4'b0000, 8'b00_00_00_00, 4'b0000, 16'h0000, 4'b0000);
    // Slave 3 finish timing with a waiting requester.
    addVec("t3 req",         4'b0110, 8'b00_11_11_00, 4'b0000, 16'h0000, 4'b0000);
    addVec("t3 M1",          4'b0110, 8'b00_11_11_00, 4'b0000, 16'h2000, 4'b1000);
    addVec("t3 M1 hold",     4'b0110, 8'b00_11_11_00, 4'b0000, 16'h2000, 4'b1000);
    addVec("t3 fin t",       4'b0110, 8'b00_11_11_00, 4'b1000, 16'h0000, 4'b1000);
    addVec("t3 t+1",         4'b0110, 8'b00_11_11_00, 4'b0000, 16'h0000, 4'b0000);
    addVec("t3 t+2",         4'b0110, 8'b00_11_11_00, 4'b0000, 16'h0000, 4'b0000);
    addVec("t3 t+3 M2",      4'b0110, 8'b00_11_11_00, 4'b0000, 16'h4000, 4'b1000);
    addVec("t3 close",       4'b0000, 8'b00_11_11_00, 4'b1000, 16'h0000, 4'b1000);
    addVec("t3 release",     4'b0000, 8'b00_00_00_00, 4'b0000, 16'h0000, 4'b0000);
    addVec("t3 idle",        4'b0000, 8'b00_00_00_00, 4'b0000, 16'h0000, 4'b0000);
    // Parallel grants on disjoint slaves, then a mid-session drop on slave 2.
    addVec("t4 req",         4'b0011, 8'b00_00_11_00, 4'b0000, 16'h0000, 4'b0000);
    addVec("t4 parallel",    4'b0011, 8'b00_00_11_00, 4'b0000, 16'h2001, 4'b1001);
    addVec("t5 M2 req",      4'b0111, 8'b00_10_11_00, 4'b0000, 16'h2001, 4'b1001);
    addVec("t5 M2 grant",    4'b0111, 8'b00_10_11_00, 4'b0000, 16'h2401, 4'b1101);
    addVec("t5 M2 drops",    4'b0011, 8'b00_01_11_00, 4'b0000, 16'h2401, 4'b1101);
    addVec("t5 M3 ignored",  4'b1011, 8'b10_01_11_00, 4'b0000, 16'h2401, 4'b1101);
    addVec("t5 fin s2",      4'b1011, 8'b10_01_11_00, 4'b0100, 16'h2001, 4'b1101);
    addVec("t5 release s2",  4'b1011, 8'b10_01_11_00, 4'b0000, 16'h2001, 4'b1001);
    addVec("t5 idle s2",     4'b1011, 8'b10_01_11_00, 4'b0000, 16'h2001, 4'b1001);
    addVec("t5 M3 grant",    4'b1011, 8'b10_01_11_00, 4'b0000, 16'h2801, 4'b1101);
    addVec("t5 close all",   4'b0000, 8'b00_00_00_00, 4'b1101, 16'h0000, 4'b1101);
    addVec("t5 fin in rel",  4'b0000, 8'b00_00_00_00, 4'b0100, 16'h0000, 4'b0000);
    addVec("t5 idle",        4'b0000, 8'b00_00_00_00, 4'b0000, 16'h0000, 4'b0000);
    addVec("t5 fin in idle", 4'b0000, 8'b00_00_00_00, 4'b1111, 16'h0000, 4'b0000);
    addVec("t5 still idle",  4'b0000, 8'b00_00_00_00, 4'b0000, 16'h0000, 4'b0000);

    #1 rst_n = 1'b0;
    #1;
    checkValue("reset granted_matrix", 16'(bus.granted_matrix), 16'h0000);
    checkValue("reset slave_busy", 16'(bus.slave_busy), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Asynchronous reset in the middle of a session, then M0 vs M3 on slave 0:
    // without the pointer reset, slave 0's pointer would favour M3 here.
    applyStimulus(mkVec("t6 req", 4'b0100, 8'b00_00_00_00, 4'b0000, 16'h0000, 4'b0000));
    checkOutput();
    applyStimulus(mkVec("t6 grant", 4'b0100, 8'b00_00_00_00, 4'b0000, 16'h0004, 4'b0001));
    checkOutput();
    #2;
    rst_n          = 1'b0;
    bus.master_req = '0;
    #1;
    checkValue("t6 async granted_matrix", 16'(bus.granted_matrix), 16'h0000);
    checkValue("t6 async slave_busy", 16'(bus.slave_busy), 16'h0000);
    #1;
    rst_n = 1'b1;
    applyStimulus(mkVec("t6 contend", 4'b1001, 8'b00_00_00_00, 4'b0000, 16'h0000, 4'b0000));
    checkOutput();
    applyStimulus(mkVec("t6 M0 wins", 4'b1001, 8'b00_00_00_00, 4'b0000, 16'h0001, 4'b0001));
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
